// File: rtl/opr_dispatch_pkg.sv
// Shared selector constants and decode helpers for the operand dispatcher.
// The broadcast code depends on the selector width, so it is produced by a function.
package opr_dispatch_pkg;

    localparam int unsigned SEL_NOP = 0;

    typedef enum logic [1:0] {
        SelNop,
        SelUnicast,
        SelBcast,
        SelIllegal
    } sel_class_e;

    function automatic int unsigned sel_bcast(input int unsigned sel_w);
        return (32'd1 << sel_w) - 32'd1;
    endfunction

    function automatic sel_class_e decode_sel(input int unsigned sel,
                                              input int unsigned sel_w,
                                              input int unsigned num_ch);
        if (sel == SEL_NOP) return SelNop;
        if (sel == sel_bcast(sel_w)) return SelBcast;
        if (sel <= num_ch) return SelUnicast;
        return SelIllegal;
    endfunction

endpackage

// File: rtl/operand_slot.sv
// One-entry valid/ready holding register for a single destination channel.
// With ZERO_IDLE set, the data register is cleared whenever the slot empties.
module operand_slot #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ZERO_IDLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // A load in the drain cycle wins, keeping the slot full back to back.
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (!valid_d && ZERO_IDLE != 0) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/operand_dispatch.sv
// Routes one operand per cycle to a channel slot, to all slots, or drops it.
// Only in_ready is combinational; every other output comes straight from a register.
module operand_dispatch
    import opr_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned ZERO_IDLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_operand,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH*DATA_W-1:0] ch_operand,
    output logic                     err_illegal,
    output logic [7:0]               drop_cnt
);

    sel_class_e        sel_cls;
    logic [NUM_CH-1:0] uni_hit;
    logic [NUM_CH-1:0] slot_free;
    logic [NUM_CH-1:0] slot_load;
    logic              xfer;
    logic              err_q, err_d;
    logic [7:0]        drop_q, drop_d;

    assign sel_cls = decode_sel(32'(in_sel), SEL_W, NUM_CH);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign uni_hit[k]   = (in_sel == SEL_W'(k + 1));
        assign slot_free[k] = !ch_valid[k] || ch_ready[k];
        assign slot_load[k] = xfer && ((sel_cls == SelUnicast && uni_hit[k]) ||
                                       sel_cls == SelBcast);

        operand_slot #(
            .DATA_W    (DATA_W),
            .ZERO_IDLE (ZERO_IDLE)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (slot_load[k]),
            .data_i  (in_operand),
            .ready_i (ch_ready[k]),
            .valid_o (ch_valid[k]),
            .data_o  (ch_operand[k*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            unique case (sel_cls)
                SelUnicast: in_ready = |(uni_hit & slot_free);
                SelBcast:   in_ready = &slot_free;
                default:    in_ready = 1'b1;
            endcase
        end
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        err_d  = xfer && (sel_cls == SelIllegal);
        drop_d = drop_q;
        if (xfer && (sel_cls == SelNop || sel_cls == SelIllegal) && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign err_illegal = err_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_operand_dispatch.sv
// Directed-vector bench for operand_dispatch with default parameters.
module tb_operand_dispatch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_operand;
    logic [2:0]  in_sel;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready;
    logic [31:0] ch_operand;
    logic        err_illegal;
    logic [7:0]  drop_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    operand_dispatch #(
        .DATA_W    (8),
        .NUM_CH    (4),
        .SEL_W     (3),
        .ZERO_IDLE (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_operand  (in_operand),
        .in_sel      (in_sel),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .ch_operand  (ch_operand),
        .err_illegal (err_illegal),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] sel, input logic [7:0] op);
        in_valid   = 1'b1;
        in_sel     = sel;
        in_operand = op;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 3'd0;
        in_operand = 8'h00;
        ch_ready   = 4'b0000;
        #1;
        check_eq("ready_in_reset", 32'(in_ready), 32'd0);
        step();
        step();
        check_eq("rst_valid", 32'(ch_valid), 32'h0);
        check_eq("rst_data", ch_operand, 32'h0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_err", 32'(err_illegal), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // Unicast to channel 1 with all consumers ready.
        ch_ready = 4'b1111;
        offer(3'd2, 8'hA5);
        #1;
        check_eq("uni_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("uni_valid", 32'(ch_valid), 32'h2);
        check_eq("uni_data", ch_operand, 32'h0000_A500);
        step();
        check_eq("uni_drained", 32'(ch_valid), 32'h0);
        check_eq("uni_zeroed", ch_operand, 32'h0);

        // Backpressure on channel 0.
        ch_ready = 4'b0000;
        offer(3'd1, 8'h11);
        step();
        check_eq("bp_fill", ch_operand, 32'h0000_0011);
        offer(3'd1, 8'h22);
        #1;
        check_eq("bp_stall_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("bp_hold_valid", 32'(ch_valid), 32'h1);
        check_eq("bp_hold_data", ch_operand, 32'h0000_0011);
        ch_ready = 4'b0001;
        #1;
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        ch_ready = 4'b0000;
        check_eq("bp_reload_valid", 32'(ch_valid), 32'h1);
        check_eq("bp_reload_data", ch_operand, 32'h0000_0022);

        // Broadcast blocked by stalled channel 3.
        offer(3'd4, 8'h44);
        step();
        check_eq("bc_pre_valid", 32'(ch_valid), 32'h9);
        ch_ready = 4'b0111;
        offer(3'd7, 8'h3C);
        #1;
        check_eq("bc_stall_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("bc_stall_valid", 32'(ch_valid), 32'h8);
        check_eq("bc_stall_data", ch_operand, 32'h4400_0000);
        ch_ready = 4'b1111;
        #1;
        check_eq("bc_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        ch_ready = 4'b0000;
        check_eq("bc_valid", 32'(ch_valid), 32'hF);
        check_eq("bc_data", ch_operand, 32'h3C3C_3C3C);

        // Illegal selector: dropped, flagged, counted.
        offer(3'd5, 8'hEE);
        #1;
        check_eq("ill_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("ill_err", 32'(err_illegal), 32'd1);
        check_eq("ill_valid", 32'(ch_valid), 32'hF);
        check_eq("ill_data", ch_operand, 32'h3C3C_3C3C);
        check_eq("ill_drop", 32'(drop_cnt), 32'd1);
        step();
        check_eq("ill_err_once", 32'(err_illegal), 32'd0);

        // Inputs without in_valid must not reach a slot.
        in_valid   = 1'b0;
        in_sel     = 3'd1;
        in_operand = 8'h99;
        step();
        check_eq("idle_data", ch_operand, 32'h3C3C_3C3C);

        // Saturating drop counter.
        offer(3'd0, 8'h00);
        step();
        check_eq("nop_drop", 32'(drop_cnt), 32'd2);
        check_eq("nop_no_err", 32'(err_illegal), 32'd0);
        for (int i = 1; i < 300; i++) step();
        in_valid = 1'b0;
        check_eq("sat_drop", 32'(drop_cnt), 32'd255);
        check_eq("sat_valid", 32'(ch_valid), 32'hF);

        // Reset with every slot full.
        rst_n = 1'b0;
        offer(3'd0, 8'h00);
        #1;
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        check_eq("mid_rst_valid", 32'(ch_valid), 32'h0);
        check_eq("mid_rst_data", ch_operand, 32'h0);
        check_eq("mid_rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_dispatch.md
OPERAND_DISPATCH -- requirements
Module: operand_dispatch

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of destination channels (1..6).
REQ-003 SHALL have parameter SEL_W, default 3, meaning selector width; 2**SEL_W-1 > NUM_CH is required.
REQ-004 SHALL have parameter ZERO_IDLE, default 1, meaning 1 = ch_operand reads zero when its channel is not valid, 0 = last value is held.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1, meaning an operand is offered.
REQ-008 SHALL have port in_ready, output, 1, meaning the offer is accepted this cycle.
REQ-009 SHALL have port in_operand, input, DATA_W, meaning the operand value.
REQ-010 SHALL have port in_sel, input, SEL_W, meaning the destination code.
REQ-011 SHALL have port ch_valid, output, NUM_CH, meaning the per-channel slot holds an operand.
REQ-012 SHALL have port ch_ready, input, NUM_CH, meaning the per-channel consumer takes the slot this cycle.
REQ-013 SHALL have port ch_operand, output, NUM_CH*DATA_W, meaning flattened slot data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port err_illegal, output, 1, meaning a one-cycle pulse when an illegal selector is consumed.
REQ-015 SHALL have port drop_cnt, output, 8, meaning a saturating count of NOP plus illegal operands consumed.

Function
REQ-016 SHALL decode in_sel as follows: 0 = NOP; 1..NUM_CH = channel in_sel-1; all-ones = BROADCAST; any other value = ILLEGAL.
REQ-017 SHALL define a transfer as in_valid && in_ready sampled at the rising edge.
REQ-018 SHALL drive in_ready combinationally for unicast as !ch_valid[t] || ch_ready[t], where t is the decoded channel.
REQ-019 SHALL drive in_ready for BROADCAST as the AND over all channels of (!ch_valid[k] || ch_ready[k]).
REQ-020 SHALL drive in_ready = 1 for NOP and ILLEGAL, which are always consumed.
REQ-021 SHALL, on a unicast transfer, load the slot for channel t and set ch_valid[t] in the following cycle, giving 1-cycle latency.
REQ-022 SHALL, on a BROADCAST transfer, load every slot with in_operand and set all ch_valid bits together.
REQ-023 SHALL clear ch_valid[k] after ch_valid[k] && ch_ready[k] unless the same cycle reloads the slot; a simultaneous drain and reload leaves ch_valid[k] = 1 holding the new value, giving full throughput.
REQ-024 SHALL ignore ch_ready[k] while ch_valid[k] = 0.
REQ-025 SHALL pulse err_illegal high for exactly the cycle after an ILLEGAL transfer, with no slot change.
REQ-026 SHALL increment drop_cnt by 1 on each NOP or ILLEGAL transfer and saturate it at 255, never wrapping.
REQ-027 SHALL, with ZERO_IDLE = 1, force ch_operand for channel k to 0 whenever ch_valid[k] = 0.
REQ-028 SHALL keep slot data stable while ch_valid[k] = 1 && ch_ready[k] = 0.
REQ-029 SHALL never change in_operand or in_sel into a slot without a transfer; values on these inputs while in_valid = 0 have no effect.

Reset
REQ-030 SHALL, while rst_n = 0 at a clock edge, set ch_valid = 0, every slot = 0, err_illegal = 0 and drop_cnt = 0.
REQ-031 SHALL discard any slot contents when reset is asserted mid-operation, with no drain handshake completed.
REQ-032 SHALL drive in_ready = 0 while rst_n = 0.

Structure
REQ-033 SHALL place the selector constants (SEL_NOP = 0, SEL_BCAST = all-ones) and the decode-class enum (NOP, UNICAST, BCAST, ILLEGAL) in a shared package, opr_dispatch_pkg.
REQ-034 SHALL instantiate one sub-module, operand_slot, per channel; each is a one-entry valid/ready register with load, drain and ZERO_IDLE masking.
REQ-035 SHALL register all outputs except in_ready, which is combinational.

Verification
REQ-036 SHALL cover unicast: sel=2, operand=0xA5, ch_ready=all-ones -> ch_valid=0b0010 and channel 1 data 0xA5 next cycle, cleared the cycle after.
REQ-037 SHALL cover backpressure: channel 0 full, ch_ready[0]=0, sel=1 offered -> in_ready=0 and slot holds the old value; raise ch_ready[0] -> same-cycle reload with ch_valid[0] staying 1.
REQ-038 SHALL cover broadcast: sel=7, operand=0x3C, channel 3 full and stalled -> in_ready=0; release channel 3 -> all four slots = 0x3C and ch_valid=0b1111.
REQ-039 SHALL cover illegal select: sel=5 with NUM_CH=4 -> err_illegal pulses once, ch_valid unchanged, drop_cnt increments.
REQ-040 SHALL cover saturation: 300 NOP transfers -> drop_cnt = 255.
REQ-041 SHALL cover reset mid-operation: rst_n=0 with all slots full -> ch_valid=0, ch_operand all 0, drop_cnt=0 after the edge.
